// File: rtl/bidir_cnt_pkg.sv
// Shared types and constants for the bidirectional-bus counter.
package bidir_cnt_pkg;
  localparam int TURN_MAX = 3;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    TURN_OUT = 2'd1,
    COUNT    = 2'd2
  } state_t;
endpackage

// File: rtl/bidir_cnt_param_if.sv
// Control/datapath link between the bus FSM and the counter core.
interface bidir_cnt_param_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             run;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             wrap;

  modport ctrl (output start, run, up, limit, input  count, wrap);
  modport core (input  start, run, up, limit, output count, wrap);
endinterface

// File: rtl/bidir_cnt_core.sv
// Up/down counter with start load, wrap-or-saturate at terminal and a
// registered terminal pulse.
module bidir_cnt_core #(
  parameter int WIDTH = 5,
  parameter bit WRAP  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bidir_cnt_param_if.core  cif
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             term;
  logic [WIDTH-1:0] reload;

  assign term   = cif.up ? (count_q == cif.limit) : (count_q == '0);
  assign reload = cif.up ? '0 : cif.limit;

  always_comb begin
    count_d = '0;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (cif.start) begin
      count_d = reload;
    end else if (cif.run) begin
      if (term) begin
        if (WRAP) begin
          count_d = reload;
          wrap_d  = 1'b1;
        end else begin
          // Holding at terminal: pulse only on the first cycle of saturation.
          count_d = count_q;
          wrap_d  = ~sat_q;
          sat_d   = 1'b1;
        end
      end else begin
        count_d = cif.up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign cif.count = count_q;
  assign cif.wrap  = wrap_q;
endmodule

// File: rtl/bidir_cnt_param.sv
// Counter sharing one bus: limit loaded from bidir, then count driven back
// onto it after a turnaround gap.
module bidir_cnt_param
  import bidir_cnt_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int TURN  = 1,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  inout  wire  [WIDTH-1:0] bidir,
  output logic             drv,
  output logic             wrap
);
  localparam int       TURN_C    = (TURN > TURN_MAX) ? TURN_MAX : TURN;
  localparam bit [1:0] TURN_LAST = (TURN_C == 0) ? 2'd0 : 2'(TURN_C - 1);

  state_t           state_q, state_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  bidir_cnt_param_if #(.WIDTH(WIDTH)) cif ();

  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    limit_d = limit_q;
    unique case (state_q)
      LOAD: begin
        limit_d = bidir;
        if (en) state_d = (TURN_C == 0) ? COUNT : TURN_OUT;
      end
      TURN_OUT: begin
        if (!en)                       state_d = LOAD;
        else if (tcnt_q == TURN_LAST)  state_d = COUNT;
        else                           tcnt_d  = tcnt_q + 2'd1;
      end
      COUNT: begin
        if (!en) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      tcnt_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      limit_q <= limit_d;
    end
  end

  assign cif.start = (state_q != COUNT) && (state_d == COUNT);
  assign cif.run   = (state_q == COUNT) && en;
  assign cif.up    = up;
  assign cif.limit = limit_q;

  bidir_cnt_core #(.WIDTH(WIDTH), .WRAP(WRAP)) u_core (
    .clk (clk),
    .rst (rst),
    .cif (cif.core)
  );

  // en gates the driver directly so the bus frees in the cycle en drops.
  assign drv   = en && (state_q == COUNT);
  assign bidir = drv ? cif.count : {WIDTH{1'bz}};
  assign wrap  = cif.wrap && (state_q == COUNT);
endmodule

// File: tb/tb_bidir_cnt_param.sv
// Directed bench: a wrapping and a saturating instance run the same stimulus.
module tb_bidir_cnt_param;
  logic       clk = 1'b0;
  logic       rst, en, up;
  logic       tb_oe;
  logic [4:0] tb_val;
  wire  [4:0] bidir_w, bidir_s;
  logic       drv_w, drv_s, wrap_w, wrap_s;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign bidir_w = tb_oe ? tb_val : 5'bz;
  assign bidir_s = tb_oe ? tb_val : 5'bz;

  bidir_cnt_param #(.WIDTH(5), .TURN(1), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .bidir(bidir_w), .drv(drv_w), .wrap(wrap_w)
  );
  bidir_cnt_param #(.WIDTH(5), .TURN(1), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .bidir(bidir_s), .drv(drv_s), .wrap(wrap_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input int cw, input int ww, input int cs, input int ws);
    chk({tag, ".drv_w"},  32'(drv_w),   1);
    chk({tag, ".cnt_w"},  32'(bidir_w), 32'(cw));
    chk({tag, ".wrap_w"}, 32'(wrap_w),  32'(ww));
    chk({tag, ".drv_s"},  32'(drv_s),   1);
    chk({tag, ".cnt_s"},  32'(bidir_s), 32'(cs));
    chk({tag, ".wrap_s"}, 32'(wrap_s),  32'(ws));
  endtask

  // Load tb_val as limit (bus already driven), then turn around into COUNT.
  task automatic enter_count();
    en = 1'b1;
    step();
    chk("turn.drv_w", 32'(drv_w), 0);
    tb_oe = 1'b0;
    step();
  endtask

  int a_cw[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
  int a_cs[8] = '{0, 1, 2, 3, 4, 5, 5, 5};
  int a_wr[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int b_cw[6] = '{3, 2, 1, 0, 3, 2};
  int b_cs[6] = '{3, 2, 1, 0, 0, 0};
  int b_wr[6] = '{0, 0, 0, 0, 1, 0};
  int c_cw[6] = '{0, 1, 2, 0, 1, 2};
  int c_cs[6] = '{0, 1, 2, 2, 2, 2};
  int c_wr[6] = '{0, 0, 0, 1, 0, 0};
  int d_ww[4] = '{0, 1, 1, 1};
  int d_ws[4] = '{0, 1, 0, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; tb_oe = 1'b1; tb_val = 5'd5;
    step();
    chk("rst.drv",   32'(drv_w), 0);
    chk("rst.wrap",  32'(wrap_w), 0);
    chk("rst.limit", 32'(dut_w.limit_q), 0);
    rst = 1'b0;
    step();
    chk("load.limit5", 32'(dut_w.limit_q), 5);

    // Up count, limit 5
    enter_count();
    for (int i = 0; i < 8; i++) begin
      chk_cyc($sformatf("up5[%0d]", i), a_cw[i], a_wr[i], a_cs[i], a_wr[i]);
      step();
    end

    // en falls mid-count: bus released in the same cycle
    en = 1'b0; tb_oe = 1'b1; tb_val = 5'd7; up = 1'b0;
    #1;
    chk("enfall.drv_w", 32'(drv_w), 0);
    chk("enfall.drv_s", 32'(drv_s), 0);
    step();
    chk("load.wrap_w", 32'(wrap_w), 0);
    chk("load.cnt_clr", 32'(dut_w.u_core.count_q), 0);
    step();
    chk("load.limit7", 32'(dut_w.limit_q), 7);
    tb_val = 5'd3;
    step();
    chk("load.limit3", 32'(dut_s.limit_q), 3);

    // Down count, limit 3
    enter_count();
    for (int i = 0; i < 6; i++) begin
      chk_cyc($sformatf("dn3[%0d]", i), b_cw[i], b_wr[i], b_cs[i], b_wr[i]);
      step();
    end

    // Up count, limit 2
    en = 1'b0; tb_oe = 1'b1; tb_val = 5'd2; up = 1'b1;
    step();
    step();
    enter_count();
    for (int i = 0; i < 6; i++) begin
      chk_cyc($sformatf("up2[%0d]", i), c_cw[i], c_wr[i], c_cs[i], c_wr[i]);
      step();
    end

    // en pulse confined to TURN_OUT: never drives, limit frozen
    en = 1'b0; tb_oe = 1'b1;
    step();
    en = 1'b1;
    step();
    chk("tpulse.drv_t", 32'(drv_w), 0);
    en = 1'b0; tb_val = 5'd9;
    #1;
    chk("tpulse.drv_f", 32'(drv_w), 0);
    step();
    chk("tpulse.drv_l", 32'(drv_w), 0);
    chk("tpulse.limit", 32'(dut_w.limit_q), 2);

    // limit 0: wrap every cycle vs single pulse
    tb_val = 5'd0;
    step();
    enter_count();
    for (int i = 0; i < 4; i++) begin
      chk_cyc($sformatf("lim0[%0d]", i), 0, d_ww[i], 0, d_ws[i]);
      step();
    end

    // Asynchronous reset mid-count while wrap is high
    #2 rst = 1'b1;
    #1;
    chk("arst.drv",   32'(drv_w), 0);
    chk("arst.wrap",  32'(wrap_w), 0);
    chk("arst.limit", 32'(dut_w.limit_q), 0);
    en = 1'b0; tb_oe = 1'b1; tb_val = 5'd6;
    step();
    rst = 1'b0;
    step();
    chk("post_rst.limit_w", 32'(dut_w.limit_q), 6);
    chk("post_rst.limit_s", 32'(dut_s.limit_q), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bidir_cnt_param.md
BIDIR_CNT_PARAM -- requirements
Module: bidir_cnt_param

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter, limit and bidir width (2..16).
REQ-002 SHALL have parameter TURN, default 1: bus-turnaround idle cycles before driving (0..3).
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap at terminal, 0 = saturate at terminal.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  0 = load phase (external drives bidir), 1 = count phase (block drives bidir).
REQ-007 SHALL have port up  input  1  count direction, 1 = up, 0 = down.
REQ-008 SHALL have port bidir  inout  WIDTH  limit in during load, count out during count.
REQ-009 SHALL have port drv  output  1  high exactly when the block drives bidir.
REQ-010 SHALL have port wrap  output  1  one-cycle registered pulse on reaching terminal count.

Function
REQ-011 SHALL implement FSM states LOAD, TURN_OUT, COUNT.
REQ-012 LOAD: bidir hi-Z; limit register captures bidir every cycle; en=1 -> TURN_OUT (TURN>0) or COUNT (TURN=0).
REQ-013 TURN_OUT: bidir hi-Z, limit frozen, internal turnaround counter runs TURN cycles, then -> COUNT; en=0 at any cycle -> LOAD.
REQ-014 COUNT: en=0 -> LOAD; drv and bidir drive SHALL be gated combinationally by en so the bus is released in the same cycle en falls (zero contention).
REQ-015 On entry to COUNT, count SHALL load start value: 0 if up=1, limit if up=0; bidir SHALL show the registered count, first driven value = start value.
REQ-016 Up count: count+1 per cycle; at count==limit: WRAP=1 -> next 0, WRAP=0 -> hold limit.
REQ-017 Down count: count-1 per cycle; at count==0: WRAP=1 -> next limit, WRAP=0 -> hold 0.
REQ-018 wrap SHALL pulse high the cycle after count equals the terminal value (limit up / 0 down); WRAP=0: once per saturation, not repeated while holding.
REQ-019 up change mid-count SHALL take effect the next cycle from the current count; count SHALL never exceed limit.
REQ-020 limit=0 SHALL hold count 0; WRAP=1 -> wrap high every COUNT cycle; WRAP=0 -> single pulse.
REQ-021 Arithmetic SHALL be WIDTH bits, no carry out; limit=2^WIDTH-1 wraps to 0 naturally.
REQ-022 Leaving COUNT SHALL clear count to 0 in LOAD; wrap SHALL be 0 outside COUNT.

Reset
REQ-023 rst SHALL immediately force state LOAD, count 0, limit 0, turnaround counter 0, wrap 0, drv 0, bidir hi-Z.
REQ-024 rst mid-COUNT SHALL release bidir asynchronously; first post-reset cycle with en=0 captures limit.

Structure
REQ-025 Package bidir_cnt_pkg SHALL hold the state enumeration and TURN_MAX=3 constant.
REQ-026 Counter datapath (start load, up/down, wrap/saturate, terminal detect) SHALL be sub-module bidir_cnt_core; FSM and tri-state in top.

Verification
REQ-027 WIDTH=5,TURN=1,WRAP=1: drive 5 with en=0, raise en, up=1 -> bidir Z one cycle, then 0,1,2,3,4,5,0; wrap after 5.
REQ-028 up=0, limit 3 -> 3,2,1,0,3; wrap one cycle after 0.
REQ-029 WRAP=0, limit 2, up=1 -> 0,1,2,2,2; wrap single pulse.
REQ-030 en falls mid-COUNT -> drv=0 and bidir Z same cycle; new external value 7 captured next edge.
REQ-031 en pulse high during TURN_OUT only -> drv never asserted, limit unchanged.
REQ-032 rst asserted mid-COUNT asynchronously -> drv=0, bidir Z, wrap=0 before next clk edge; limit reads 0.
